// File: rtl/alarm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_sequencer_pkg
//  Description : Shared state codes, default tick constants and small state
//                classification helpers for the alarm sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_sequencer_pkg;

    // Width of the delay/siren down counter and of the strobe divider.
    localparam int unsigned c_timer_w = 12;
    localparam int unsigned c_div_w   = 4;

    // Default durations, in 50 ms ticks.
    localparam int unsigned c_default_exit_ticks  = 200;   // 10 s
    localparam int unsigned c_default_entry_ticks = 200;   // 10 s
    localparam int unsigned c_default_siren_ticks = 1200;  // 60 s
    localparam int unsigned c_default_strobe_div  = 4;

    // Externally visible state encoding; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        DISARMED    = 3'd0,
        EXIT_DELAY  = 3'd1,
        ARMED       = 3'd2,
        ENTRY_DELAY = 3'd3,
        ALARM       = 3'd4,
        PANIC       = 3'd5
    } state_t;

    // States that run the delay/siren timer.
    function automatic logic is_timed(input state_t s);
        return (s == EXIT_DELAY) || (s == ENTRY_DELAY) || (s == ALARM);
    endfunction

    // States that drive the siren and strobe.
    function automatic logic is_sounding(input state_t s);
        return (s == ALARM) || (s == PANIC);
    endfunction

    // States shown on the armed indicator.
    function automatic logic is_armed(input state_t s);
        return (s == ARMED) || (s == ENTRY_DELAY) || (s == ALARM) || (s == PANIC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_sequencer_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_tick_timer
//  Description : Loadable tick-enabled down counter. Loading N makes the
//                expiry flag fire on the N-th tick after the load.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_tick_timer #(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             run,
    input  logic             tick,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over counting; the count freezes while not running
    // and never wraps below zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (run && tick && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // Expiry is the tick that consumes the last remaining count.
    assign expired = run && tick && (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/alarm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_sequencer
//  Description : Intruder alarm controller: arm/disarm with exit and entry
//                delays, instant and delayed zones, timed siren, panic key,
//                sticky zone record and flashing strobe. All outputs are
//                registered and follow the sampled inputs by one clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int unsigned EXIT_TICKS  = c_default_exit_ticks,   // 1..4095
    parameter int unsigned ENTRY_TICKS = c_default_entry_ticks,  // 1..4095
    parameter int unsigned SIREN_TICKS = c_default_siren_ticks,  // 1..4095
    parameter int unsigned STROBE_DIV  = c_default_strobe_div    // 1..15
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       tick,
    input  logic       arm_key,
    input  logic       panic_key,
    input  logic [2:0] zone_sensor,
    output logic [2:0] state,
    output logic       siren_en,
    output logic       strobe,
    output logic [2:0] zone_latched,
    output logic       armed_led,
    output logic       disarmed_led
);

    localparam logic [c_timer_w-1:0] c_exit_load   = c_timer_w'(EXIT_TICKS);
    localparam logic [c_timer_w-1:0] c_entry_load  = c_timer_w'(ENTRY_TICKS);
    localparam logic [c_timer_w-1:0] c_siren_load  = c_timer_w'(SIREN_TICKS);
    localparam logic [c_div_w-1:0]   c_strobe_last = c_div_w'(STROBE_DIV - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_arm_q;
    logic                 r_panic_q;
    logic                 w_arm_edge;
    logic                 w_panic_edge;
    logic                 w_instant_trip;
    logic                 w_entry_trip;
    logic                 w_expired;
    logic                 w_timer_load;
    logic                 w_timer_run;
    logic [c_timer_w-1:0] w_load_value;
    logic                 w_state_change;
    logic                 r_siren_en;
    logic                 r_armed_led;
    logic                 r_disarmed_led;
    logic [2:0]           r_zone_latched;
    logic                 r_strobe;
    logic [c_div_w-1:0]   r_strobe_div;

    // Key history; resets high so a key held through reset gives no edge.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_arm_q   <= 1'b1;
            r_panic_q <= 1'b1;
        end else begin
            r_arm_q   <= arm_key;
            r_panic_q <= panic_key;
        end
    end

    assign w_arm_edge     = arm_key & ~r_arm_q;
    assign w_panic_edge   = panic_key & ~r_panic_q;
    assign w_instant_trip = zone_sensor[1] | zone_sensor[2];
    assign w_entry_trip   = zone_sensor[0];

    // Next state: panic beats arm, arm beats zones, zones beat timer expiry.
    always_comb begin
        w_next_state = r_state;
        if (r_state > PANIC) begin
            w_next_state = DISARMED;
        end else if (w_panic_edge && (r_state != PANIC)) begin
            w_next_state = PANIC;
        end else if (w_arm_edge) begin
            w_next_state = (r_state == DISARMED) ? EXIT_DELAY : DISARMED;
        end else begin
            case (r_state)
                EXIT_DELAY: begin
                    if (w_expired) w_next_state = ARMED;
                end
                ARMED: begin
                    if (w_instant_trip)    w_next_state = ALARM;
                    else if (w_entry_trip) w_next_state = ENTRY_DELAY;
                end
                ENTRY_DELAY: begin
                    if (w_instant_trip || w_expired) w_next_state = ALARM;
                end
                ALARM: begin
                    if (w_expired) w_next_state = ARMED;
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    assign w_state_change = (w_next_state != r_state);

    // Timer control: reload on every entry into a timed state.
    always_comb begin
        w_timer_load = w_state_change && is_timed(w_next_state);
        w_timer_run  = is_timed(r_state);
        case (w_next_state)
            EXIT_DELAY:  w_load_value = c_exit_load;
            ENTRY_DELAY: w_load_value = c_entry_load;
            ALARM:       w_load_value = c_siren_load;
            default:     w_load_value = '0;
        endcase
    end

    alarm_tick_timer #(
        .WIDTH (c_timer_w)
    ) u_timer (
        .clk        (iCLK),
        .rst        (iRST),
        .load       (w_timer_load),
        .load_value (w_load_value),
        .run        (w_timer_run),
        .tick       (tick),
        .expired    (w_expired)
    );

    // State register and the indicator outputs decoded from the next state.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state        <= DISARMED;
            r_siren_en     <= 1'b0;
            r_armed_led    <= 1'b0;
            r_disarmed_led <= 1'b1;
        end else begin
            r_state        <= w_next_state;
            r_siren_en     <= is_sounding(w_next_state);
            r_armed_led    <= is_armed(w_next_state);
            r_disarmed_led <= (w_next_state == DISARMED) || (w_next_state == EXIT_DELAY);
        end
    end

    // Sticky zone record: cleared when a new exit delay starts, accumulates
    // while armed, holds otherwise (so the owner can see what tripped).
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_zone_latched <= '0;
        end else if ((w_next_state == EXIT_DELAY) && (r_state != EXIT_DELAY)) begin
            r_zone_latched <= '0;
        end else if ((r_state == ARMED) || (r_state == ENTRY_DELAY) || (r_state == ALARM)) begin
            r_zone_latched <= r_zone_latched | zone_sensor;
        end
    end

    // Strobe: starts lit on entry to a sounding state, flips every
    // STROBE_DIV ticks, dark elsewhere.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_strobe     <= 1'b0;
            r_strobe_div <= '0;
        end else if (is_sounding(w_next_state)) begin
            if (w_state_change) begin
                r_strobe     <= 1'b1;
                r_strobe_div <= '0;
            end else if (tick) begin
                if (r_strobe_div == c_strobe_last) begin
                    r_strobe     <= ~r_strobe;
                    r_strobe_div <= '0;
                end else begin
                    r_strobe_div <= r_strobe_div + c_div_w'(1);
                end
            end
        end else begin
            r_strobe     <= 1'b0;
            r_strobe_div <= '0;
        end
    end

    assign state        = r_state;
    assign siren_en     = r_siren_en;
    assign strobe       = r_strobe;
    assign zone_latched = r_zone_latched;
    assign armed_led    = r_armed_led;
    assign disarmed_led = r_disarmed_led;

endmodule
`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_sequencer
//  Description : Scoreboard bench for alarm_sequencer with a tick-counting
//                reference model, directed scenarios and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_sequencer;

    localparam int EXIT_T  = 4;
    localparam int ENTRY_T = 3;
    localparam int SIREN_T = 6;
    localparam int DIV     = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       arm_key = 1'b0;
    logic       panic_key = 1'b0;
    logic [2:0] zone = 3'b000;
    logic [2:0] dut_state;
    logic       siren_en;
    logic       strobe;
    logic [2:0] zone_latched;
    logic       armed_led;
    logic       disarmed_led;

    alarm_sequencer #(
        .EXIT_TICKS  (EXIT_T),
        .ENTRY_TICKS (ENTRY_T),
        .SIREN_TICKS (SIREN_T),
        .STROBE_DIV  (DIV)
    ) dut (
        .iCLK         (clk),
        .iRST         (rst),
        .tick         (tick),
        .arm_key      (arm_key),
        .panic_key    (panic_key),
        .zone_sensor  (zone),
        .state        (dut_state),
        .siren_en     (siren_en),
        .strobe       (strobe),
        .zone_latched (zone_latched),
        .armed_led    (armed_led),
        .disarmed_led (disarmed_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic       siren;
        logic       strobe;
        logic       armed;
        logic       disarmed;
        logic [2:0] lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: state number, ticks seen since entering that state,
    // zone record and the previous key levels.
    int         m_state    = 0;
    int         m_count    = 0;
    logic [2:0] m_lat      = 3'b000;
    logic       m_arm_prev = 1'b1;
    logic       m_pan_prev = 1'b1;

    function automatic void check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic int duration(input int s);
        case (s)
            1:       return EXIT_T;
            3:       return ENTRY_T;
            4:       return SIREN_T;
            default: return 0;
        endcase
    endfunction

    function automatic void model_step(input logic r, input logic t, input logic a,
                                       input logic p, input logic [2:0] z);
        exp_t e;
        int   nxt;
        logic ae, pe, done, inst;
        if (r) begin
            m_state    = 0;
            m_count    = 0;
            m_lat      = 3'b000;
            m_arm_prev = 1'b1;
            m_pan_prev = 1'b1;
        end else begin
            ae = a && !m_arm_prev;
            pe = p && !m_pan_prev;
            m_arm_prev = a;
            m_pan_prev = p;
            inst = z[1] | z[2];
            done = t && (duration(m_state) != 0) && (m_count == duration(m_state) - 1);
            nxt = m_state;
            if (pe && m_state != 5)      nxt = 5;
            else if (ae)                 nxt = (m_state == 0) ? 1 : 0;
            else if (m_state == 1 && done) nxt = 2;
            else if (m_state == 2) begin
                if (inst)      nxt = 4;
                else if (z[0]) nxt = 3;
            end
            else if (m_state == 3 && (inst || done)) nxt = 4;
            else if (m_state == 4 && done) nxt = 2;
            if (m_state >= 2 && m_state <= 4) m_lat = m_lat | z;
            if (nxt == 1 && m_state != 1) m_lat = 3'b000;
            if (nxt != m_state) m_count = 0;
            else if (t)         m_count = m_count + 1;
            m_state = nxt;
        end
        e.st       = 3'(m_state);
        e.siren    = (m_state == 4 || m_state == 5);
        e.strobe   = e.siren && (((m_count / DIV) % 2) == 0);
        e.armed    = (m_state >= 2 && m_state <= 5);
        e.disarmed = (m_state <= 1);
        e.lat      = m_lat;
        sb_q.push_back(e);
    endfunction

    // One clock of stimulus; returns shortly after the edge that samples it.
    task automatic step(input logic r, input logic t, input logic a,
                        input logic p, input logic [2:0] z);
        @(negedge clk);
        rst = r; tick = t; arm_key = a; panic_key = p; zone = z;
        model_step(r, t, a, p, z);
        @(posedge clk);
        #2;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
            step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        end
    endtask

    function automatic void expect_out(input string tag, input int st, input int sir, input int lat);
        check({tag, "_state"}, int'(dut_state), st);
        check({tag, "_siren"}, int'(siren_en), sir);
        check({tag, "_latched"}, int'(zone_latched), lat);
    endfunction

    // Monitor: every clock the DUT presents a full output set; compare it
    // against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("sb_state", int'(dut_state), int'(e.st));
                check("sb_siren", int'(siren_en), int'(e.siren));
                check("sb_strobe", int'(strobe), int'(e.strobe));
                check("sb_armed_led", int'(armed_led), int'(e.armed));
                check("sb_disarmed_led", int'(disarmed_led), int'(e.disarmed));
                check("sb_latched", int'(zone_latched), int'(e.lat));
            end
        end
    end

    initial begin
        logic ra;
        logic rp;
        ra = 1'b0;
        rp = 1'b0;

        // Reset with the arm key held through release: no arming.
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
        check("reset_disarmed_led", int'(disarmed_led), 1);
        check("reset_strobe", int'(strobe), 0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        expect_out("key_held_reset", 0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        // Arm: exit delay lasts exactly four ticks.
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        expect_out("arm_to_exit", 1, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick_n(3);
        expect_out("exit_3_ticks", 1, 0, 0);
        tick_n(1);
        expect_out("exit_done", 2, 0, 0);
        check("exit_done_armed_led", int'(armed_led), 1);

        // Delayed zone: entry delay then alarm, then siren timeout.
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
        expect_out("entry_trip", 3, 0, 1);
        tick_n(2);
        expect_out("entry_2_ticks", 3, 0, 1);
        tick_n(1);
        expect_out("entry_expired", 4, 1, 1);
        tick_n(5);
        expect_out("siren_5_ticks", 4, 1, 1);
        tick_n(1);
        expect_out("siren_timeout", 2, 0, 1);

        // Disarm during entry delay keeps the zone record.
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
        tick_n(1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        expect_out("entry_disarm", 0, 0, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        // Re-arm clears the record; instant zone alarms next cycle.
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        expect_out("rearm_clears", 1, 0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick_n(4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
        expect_out("instant_trip", 4, 1, 4);
        tick_n(6);
        expect_out("instant_timeout", 2, 0, 4);

        // Panic beats a same-cycle arm; strobe flips every two ticks.
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        expect_out("disarm_before_panic", 0, 0, 4);
        step(1'b0, 1'b0, 1'b1, 1'b1, 3'b000);
        expect_out("panic_wins", 5, 1, 4);
        check("panic_strobe_start", int'(strobe), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick_n(1);
        check("strobe_after_1_tick", int'(strobe), 1);
        tick_n(1);
        check("strobe_after_2_ticks", int'(strobe), 0);
        tick_n(2);
        check("strobe_after_4_ticks", int'(strobe), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
        expect_out("panic_disarm", 0, 0, 4);
        check("panic_disarm_strobe", int'(strobe), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            logic       r_rnd;
            logic       t_rnd;
            logic [2:0] z_rnd;
            if ($urandom_range(0, 19) == 0) ra = ~ra;
            if ($urandom_range(0, 59) == 0) rp = ~rp;
            z_rnd = ($urandom_range(0, 14) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            t_rnd = ($urandom_range(0, 2) == 0);
            r_rnd = ($urandom_range(0, 499) == 0);
            step(r_rnd, t_rnd, ra, rp, z_rnd);
        end

        repeat (2) @(posedge clk);
        #3;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
